multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: Moore FSM driving datapath
// strobes, plus a 16-bit retired-instruction counter.
// Build option: define MEM_WAIT_EN to stretch FETCH/MEMRD/MEMWR until
// mem_ready is high; otherwise mem_ready is ignored.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        illegal_op,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  ALUControl,
    output logic [3:0]  state,
    output logic [15:0] instr_retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_retired;
    logic        w_rdy;
    logic        w_retire;

`ifdef MEM_WAIT_EN
    assign w_rdy = mem_ready;
`else
    // Memory always completes in one cycle; the port is kept for pin compatibility.
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_rdy = 1'b1;
`endif

    // An instruction retires on the edge that leaves its final state.
    assign w_retire = (r_state == S_MEMWB)  || (r_state == S_ALUWB) ||
                      (r_state == S_BRANCH) || (r_state == S_JUMP)  ||
                      (r_state == S_ADDIWB) || ((r_state == S_MEMWR) && w_rdy);

    assign state         = r_state;
    assign instr_retired = r_retired;

    // State register and retire counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + 16'd1;
        end
    end

    // Next-state logic; opcode is held stable by the IR after FETCH.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_RTYPE:       w_next = S_EXEC;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    OP_ADDI:        w_next = S_ADDIEX;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; everything idles at 0 / ALU add.
    always_comb begin
        pc_en      = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        illegal_op = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUControl = 4'b0010;
        unique case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = w_rdy;
                pc_en   = w_rdy;
                ALUSrcB = 2'b01;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (funct)
                    6'b100010: ALUControl = 4'b0110;
                    6'b100100: ALUControl = 4'b0000;
                    6'b100101: ALUControl = 4'b0001;
                    6'b101010: ALUControl = 4'b0111;
                    6'b100111: ALUControl = 4'b1100;
                    default:   ALUControl = 4'b0010;
                endcase
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 4'b0110;
                PCSource   = 2'b01;
                pc_en      = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                pc_en    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver walks each instruction
// through its state list and queues the expected control word per cycle;
// a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_en, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0]  ALUSrcB, PCSource;
    logic [3:0]  ALUControl, state;
    logic [15:0] instr_retired;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .illegal_op(illegal_op),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUControl(ALUControl),
        .state(state), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  st;
        logic        pc_en, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
        logic [1:0]  asb, pcs;
        logic [3:0]  alu;
        logic [15:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   retired = 0;   // model of retired-instruction count

    // Monitor: compare every cycle for which an expectation was queued.
    always @(negedge clk) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, pc_en, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                 RegWrite, ALUSrcA, illegal_op, ALUSrcB, PCSource, ALUControl, instr_retired};
            n_vec++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ctrl_word op=%b st_want=%0d got=%h want=%h", opcode, e.st, a, e);
            end
        end
    end

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e = '0;
        e.st  = st;
        e.alu = 4'b0010;
        e.ret = retired[15:0];
        return e;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b001000};
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b0010;
        endcase
    endfunction

    task automatic cyc(input exp_t e, input bit rst);
        reset = rst;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (rst) retired = 0;
    endtask

    task automatic retire_done();
        retired = (retired + 1) % 65536;
    endtask

    // FETCH: nwait>=0 forces that many mem_ready=0 cycles; else random (bounded).
    task automatic fetch_phase(input int nwait);
        exp_t e;
        bit   rdy;
        for (int i = 0; i < 8; i++) begin
            if (nwait >= 0) mem_ready = (i < nwait) ? 1'b0 : 1'b1;
            else            mem_ready = (i >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            rdy = WAIT_EN ? mem_ready : 1'b1;
            e = blank(4'd0);
            e.mrd = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pc_en = rdy;
            cyc(e, 1'b0);
            if (rdy) break;
        end
    endtask

    // Memory access state: repeats while the memory is not ready (wait build only).
    task automatic mem_phase(input exp_t e, input bit rst_first);
        bit rdy;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            rdy = WAIT_EN ? mem_ready : 1'b1;
            e.ret = retired[15:0];
            cyc(e, rst_first && (i == 0));
            if (rdy || (rst_first && i == 0)) break;
        end
    endtask

    // One instruction from FETCH to its retiring state. z<0 means random zero.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int z,
                             input int nwait, input bit rst_memrd);
        exp_t e;
        opcode = op;
        funct  = fn;
        zero   = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
        fetch_phase(nwait);
        e = blank(4'd1); e.asb = 2'b11; e.ill = !legal(op);
        cyc(e, 1'b0);
        case (op)
            6'b100011, 6'b101011: begin
                e = blank(4'd2); e.asa = 1'b1; e.asb = 2'b10;
                cyc(e, 1'b0);
                if (op == 6'b100011) begin
                    e = blank(4'd3); e.mrd = 1'b1; e.iord = 1'b1;
                    mem_phase(e, rst_memrd);
                    if (rst_memrd) return;
                    e = blank(4'd4); e.rw = 1'b1; e.m2r = 1'b1;
                    cyc(e, 1'b0);
                end else begin
                    e = blank(4'd5); e.mwr = 1'b1; e.iord = 1'b1;
                    mem_phase(e, 1'b0);
                end
                retire_done();
            end
            6'b000000: begin
                e = blank(4'd6); e.asa = 1'b1; e.alu = alu_of(fn);
                cyc(e, 1'b0);
                e = blank(4'd7); e.rw = 1'b1; e.rdst = 1'b1;
                cyc(e, 1'b0);
                retire_done();
            end
            6'b000100, 6'b000101: begin
                e = blank(4'd8); e.asa = 1'b1; e.alu = 4'b0110; e.pcs = 2'b01;
                e.pc_en = (op == 6'b000100) ? zero : !zero;
                cyc(e, 1'b0);
                retire_done();
            end
            6'b000010: begin
                e = blank(4'd9); e.pcs = 2'b10; e.pc_en = 1'b1;
                cyc(e, 1'b0);
                retire_done();
            end
            6'b001000: begin
                e = blank(4'd10); e.asa = 1'b1; e.asb = 2'b10;
                cyc(e, 1'b0);
                e = blank(4'd11); e.rw = 1'b1;
                cyc(e, 1'b0);
                retire_done();
            end
            default: ;  // illegal: back to FETCH, nothing retired
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        retired = 0;
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [7];
        logic [5:0] op, fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b001000, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000011};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        retired = 0;

        // Directed: sub, lw, sw, beq/bne with zero=1, illegal, reset inside MEMRD.
        run_instr(6'b000000, 6'b100010, 0, -1, 1'b0);
        run_instr(6'b100011, 6'b000000, 0, -1, 1'b0);
        run_instr(6'b101011, 6'b000000, 0, -1, 1'b0);
        run_instr(6'b000100, 6'b000000, 1, -1, 1'b0);
        run_instr(6'b000101, 6'b000000, 1, -1, 1'b0);
        run_instr(6'b111111, 6'b000000, 0, -1, 1'b0);
        run_instr(6'b100011, 6'b000000, 0, -1, 1'b1);
        run_instr(6'b000000, 6'b111111, 0, -1, 1'b0);
        // Three not-ready FETCH cycles (held in wait build, ignored otherwise).
        run_instr(6'b001000, 6'b000000, 0, 3, 1'b0);

        // Random mix of legal, illegal and unlisted-funct instructions.
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_instr(op, fn, -1, -1, 1'b0);
        end

        // Counter wrap: 65535 jumps from reset reach FFFF, the next one wraps.
        do_reset();
        for (int i = 0; i < 65536; i++)
            run_instr(6'b000010, 6'b000000, -1, -1, 1'b0);
        run_instr(6'b000000, 6'b100000, -1, -1, 1'b0);

        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
